fmap_stream_serializer: RTL and testbench
=========================================

// Module: fmap_stream_serializer
// PURPOSE
//   Consumer side of the conv2d feature-map output bus. Captures a whole parallel feature-map
//   frame (NUM_ELEMS elements of ELEM_W bits) and re-emits it one element per cycle on a
//   valid/ready stream with out_last on the final element.
//   Ping-pong double buffer: a new frame can be captured while the previous one streams out.
//   Sits between conv2d and downstream pooling/dense stages.
// PARAMETERS
//   NUM_ELEMS  32  elements per frame (conv2d INPUT_WIDTH*INPUT_HEIGHT); must be >= 2
//   ELEM_W     32  bits per element (conv2d NUM_FILTERS slice width)
// PORTS
//   clk          in   1                  clock
//   rst_n        in   1                  reset, asynchronous, active-low
//   in_data      in   NUM_ELEMS*ELEM_W   parallel frame; element e = in_data[e*ELEM_W +: ELEM_W]
//   in_valid     in   1                  frame present (conv2d data_out_valid)
//   in_ready     out  1                  a buffer is free; capture happens on in_valid&&in_ready
//   out_data     out  ELEM_W             current element
//   out_valid    out  1                  out_data valid
//   out_ready    in   1                  downstream accepts; transfer = out_valid&&out_ready
//   out_last     out  1                  high with element NUM_ELEMS-1
//   drop_cnt     out  16                 frames offered while in_ready=0 (see CONFIGURATION)
// BEHAVIOUR
//   - State: buf[0..1] frame registers, full[1:0], wr_sel, rd_sel, idx ($clog2(NUM_ELEMS) bits).
//   - Reset (async): full=0, wr_sel=0, rd_sel=0, idx=0, drop_cnt=0.
//     Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0.
//     Buffer contents are not reset.
//   - in_ready = ~full[wr_sel], from registered flags only. A buffer freed in the same cycle is
//     not reusable until the next cycle; no combinational ready path.
//   - Capture: on in_valid&&in_ready, buf[wr_sel]<=in_data, full[wr_sel]<=1, wr_sel toggles.
//   - Stream: out_valid = full[rd_sel]; out_data = buf[rd_sel][idx]; out_last = out_valid && idx==NUM_ELEMS-1.
//     out_data/out_last are 0 whenever out_valid=0.
//   - Latency: a capture at edge N gives first element valid after edge N when the reader is idle.
//   - On transfer with idx<NUM_ELEMS-1: idx++.
//   - On transfer with idx==NUM_ELEMS-1: idx<=0, full[rd_sel]<=0, rd_sel toggles.
//     If the other buffer is full, the next frame streams back-to-back with no bubble.
//   - Stall: while out_valid && !out_ready, out_data and out_last hold stable.
//   - Simultaneous: a capture into one buffer and a final transfer from the other in the same
//     cycle are both honoured. full[] updates are independent per buffer.
//   - Frames leave in capture order. No frame is ever partially overwritten.
//   - Reset mid-frame aborts the stream immediately; the partial frame is discarded.
// CONFIGURATION
//   FMAP_SER_DROP_CNT_EN defined: drop_cnt increments on each cycle with in_valid && !in_ready.
//     It saturates at 16'hFFFF. Needed because conv2d does not honour backpressure.
//   Not defined: drop_cnt is tied to 16'h0 and no counter logic is built. Port list is unchanged.
// STRUCTURE
//   Shared package ecko_fmap_pkg holds:
//     - FMAP_ELEM_W / FMAP_NUM_ELEMS defaults shared with conv2d
//     - idx width localparam
//     - drop counter width (16)
//   One sub-module: fmap_frame_buf, a single frame register with load enable and an element
//   read mux. It is instantiated twice. Control (flags, pointers, idx, counter) stays at top level.
// TESTING  (NUM_ELEMS=4, ELEM_W=8)
//   1. Single frame: in_data=32'h44332211, in_valid 1 cycle, out_ready=1.
//      -> out_data 11,22,33,44 on 4 consecutive cycles starting 1 cycle after capture.
//      -> out_last only with 44; then out_valid=0, in_ready=1.
//   2. Backpressure: same frame, out_ready toggled 1,0,0,1,...
//      -> each element held stable during stalls; no loss or duplication; order 11,22,33,44.
//   3. Back-to-back: frames A=32'h04030201, B=32'h08070605 on consecutive cycles, out_ready=1.
//      -> 01..04 then 05..08 with no bubble; out_last on 04 and 08.
//   4. Full/drop: out_ready=0, offer 3 frames on 3 cycles.
//      -> first two captured, in_ready=0 on 3rd; drop_cnt=1 with macro, 0 without.
//      -> releasing out_ready yields exactly 2 frames.
//   5. Free-and-capture: both buffers full, final transfer of frame 1 in cycle N, in_valid in N.
//      -> not captured in N (in_ready=0); in_ready=1 in N+1 and capture succeeds.
//   6. Reset mid-stream: assert rst_n=0 after 2nd element.
//      -> out_valid=0 immediately; after release, the next frame streams from element 0.

Source files
------------

// File: rtl/ecko_fmap_pkg.sv
// Shared feature-map definitions used by conv2d and the stream serializer.
// Holds the default frame geometry, the element index width and the drop counter width.
package ecko_fmap_pkg;

  localparam int FMAP_ELEM_W     = 32;
  localparam int FMAP_NUM_ELEMS  = 32;
  localparam int FMAP_IDX_W      = $clog2(FMAP_NUM_ELEMS);
  localparam int FMAP_DROP_CNT_W = 16;

endpackage

// File: rtl/fmap_stream_serializer_if.sv
// Handshake bundle for the serializer.
// The parallel frame input side and the element stream output side travel together.
// The slave modport is the serializer's view; the master modport is the surrounding logic.
interface fmap_stream_serializer_if
  import ecko_fmap_pkg::*;
#(
  parameter int NUM_ELEMS = FMAP_NUM_ELEMS,
  parameter int ELEM_W    = FMAP_ELEM_W
);

  logic [NUM_ELEMS*ELEM_W-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [ELEM_W-1:0]           out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/fmap_frame_buf.sv
// One frame register of the ping-pong pair.
// It loads a whole parallel frame on i_load and returns the element selected by i_idx.
// Contents are deliberately not reset; the full flags at top level decide what is meaningful.
module fmap_frame_buf #(
  parameter int NUM_ELEMS = 32,
  parameter int ELEM_W    = 32,
  parameter int IDX_W     = 5
) (
  input  logic                        clk,
  input  logic                        i_load,
  input  logic [NUM_ELEMS*ELEM_W-1:0] i_frame,
  input  logic [IDX_W-1:0]            i_idx,
  output logic [ELEM_W-1:0]           o_elem
);

  logic [NUM_ELEMS-1:0][ELEM_W-1:0] r_frame;

  // Capture the whole frame at once so a frame is never partially overwritten
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_frame <= i_frame;
    end
  end

  assign o_elem = r_frame[i_idx];

endmodule

// File: rtl/fmap_stream_serializer.sv
// Feature-map stream serializer: captures parallel conv2d frames into a ping-pong
// pair of frame buffers and re-emits them one element per cycle with a last flag.
// Optional feature macro: FMAP_SER_DROP_CNT_EN builds a saturating counter of frames
// offered while no buffer was free; without it o_drop_cnt is tied to zero.
module fmap_stream_serializer
  import ecko_fmap_pkg::*;
#(
  parameter int NUM_ELEMS = FMAP_NUM_ELEMS,
  parameter int ELEM_W    = FMAP_ELEM_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fmap_stream_serializer_if.slave    bus,
  output logic [FMAP_DROP_CNT_W-1:0] o_drop_cnt
);

  localparam int IDX_W = $clog2(NUM_ELEMS);

  logic [1:0]        r_full;
  logic              r_wrSel;
  logic              r_rdSel;
  logic [IDX_W-1:0]  r_idx;

  logic              w_inReady;
  logic              w_capture;
  logic              w_outValid;
  logic              w_transfer;
  logic              w_lastIdx;
  logic              w_finish;
  logic [ELEM_W-1:0] w_elem0;
  logic [ELEM_W-1:0] w_elem1;

  assign w_inReady  = ~r_full[r_wrSel];
  assign w_capture  = bus.in_valid & w_inReady;
  assign w_outValid = r_full[r_rdSel];
  assign w_transfer = w_outValid & bus.out_ready;
  assign w_lastIdx  = (r_idx == IDX_W'(NUM_ELEMS - 1));
  assign w_finish   = w_transfer & w_lastIdx;

  fmap_frame_buf #(
    .NUM_ELEMS (NUM_ELEMS),
    .ELEM_W    (ELEM_W),
    .IDX_W     (IDX_W)
  ) u_buf0 (
    .clk     (clk),
    .i_load  (w_capture & ~r_wrSel),
    .i_frame (bus.in_data),
    .i_idx   (r_idx),
    .o_elem  (w_elem0)
  );

  fmap_frame_buf #(
    .NUM_ELEMS (NUM_ELEMS),
    .ELEM_W    (ELEM_W),
    .IDX_W     (IDX_W)
  ) u_buf1 (
    .clk     (clk),
    .i_load  (w_capture & r_wrSel),
    .i_frame (bus.in_data),
    .i_idx   (r_idx),
    .o_elem  (w_elem1)
  );

  // Buffer flags and pointers: a capture and a final read touch different buffers,
  // so both flag updates may land in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 2'b00;
      r_wrSel <= 1'b0;
      r_rdSel <= 1'b0;
    end else begin
      if (w_capture) begin
        r_full[r_wrSel] <= 1'b1;
        r_wrSel         <= ~r_wrSel;
      end
      if (w_finish) begin
        r_full[r_rdSel] <= 1'b0;
        r_rdSel         <= ~r_rdSel;
      end
    end
  end

  // Element index walks the frame and wraps so the next buffer starts at element 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_transfer) begin
      r_idx <= w_lastIdx ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_data  = !w_outValid ? '0 : (r_rdSel ? w_elem1 : w_elem0);
  assign bus.out_last  = w_outValid & w_lastIdx;

`ifdef FMAP_SER_DROP_CNT_EN
  logic [FMAP_DROP_CNT_W-1:0] r_dropCnt;

  // Count frames conv2d pushed while both buffers were busy, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (bus.in_valid && !w_inReady && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + FMAP_DROP_CNT_W'(1);
    end
  end

  assign o_drop_cnt = r_dropCnt;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fmap_stream_serializer.sv
// Self-checking bench for fmap_stream_serializer with NUM_ELEMS=4, ELEM_W=8.
// A queue-of-frames reference model predicts every output each cycle; directed
// scenarios are followed by randomized traffic and a random mid-stream reset.
module tb_fmap_stream_serializer;

  localparam int ELEMS   = 4;
  localparam int EW      = 8;
  localparam int FRAME_W = ELEMS * EW;

  logic        clk;
  logic        rst_n;
  logic [15:0] dropCnt;

  fmap_stream_serializer_if #(.NUM_ELEMS(ELEMS), .ELEM_W(EW)) bus ();

  fmap_stream_serializer #(
    .NUM_ELEMS (ELEMS),
    .ELEM_W    (EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .o_drop_cnt (dropCnt)
  );

  int compared;
  int mismatched;

  logic [FRAME_W-1:0] frameQ[$];
  int                 headPos;
  int                 expDrop;

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    frameQ.delete();
    headPos = 0;
    expDrop = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, check at the falling edge,
  // then advance the model as the coming rising edge will
  task automatic applyStimulus(input logic v, input logic [FRAME_W-1:0] d, input logic r);
    logic         expReady;
    logic         expValid;
    logic         expLast;
    logic [EW-1:0] expData;
    logic [FRAME_W-1:0] head;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(negedge clk);
    expReady = (frameQ.size() < 2);
    expValid = (frameQ.size() > 0);
    expData  = '0;
    expLast  = 1'b0;
    if (expValid) begin
      head    = frameQ[0];
      expData = head[headPos*EW +: EW];
      expLast = (headPos == ELEMS - 1);
    end
    checkOutput("in_ready",  32'(bus.in_ready),  32'(expReady));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
    checkOutput("out_data",  32'(bus.out_data),  32'(expData));
    checkOutput("out_last",  32'(bus.out_last),  32'(expLast));
    checkOutput("drop_cnt",  32'(dropCnt),       32'(expDrop));
    if (expValid && r) begin
      headPos++;
      if (headPos == ELEMS) begin
        void'(frameQ.pop_front());
        headPos = 0;
      end
    end
    if (v && expReady) begin
      frameQ.push_back(d);
    end
`ifdef FMAP_SER_DROP_CNT_EN
    if (v && !expReady && expDrop < 65535) expDrop++;
`endif
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear without waiting for an edge
  task automatic doReset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_last",  32'(bus.out_last),  32'd0);
    checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_drop_cnt",  32'(dropCnt),       32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    modelReset();
    #2;
    doReset();

    $display("[TB] single frame");
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    idle(6);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    begin
      logic pattern [8];
      pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, pattern[i]);
    end
    idle(3);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 32'h04030201, 1'b1);
    applyStimulus(1'b1, 32'h08070605, 1'b1);
    idle(9);

    $display("[TB] full and drop");
    applyStimulus(1'b1, 32'hA4A3A2A1, 1'b0);
    applyStimulus(1'b1, 32'hB4B3B2B1, 1'b0);
    applyStimulus(1'b1, 32'hC4C3C2C1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    idle(10);

    $display("[TB] free and capture");
    applyStimulus(1'b1, 32'hD4D3D2D1, 1'b0);
    applyStimulus(1'b1, 32'hE4E3E2E1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 32'hF4F3F2F1, 1'b1);
    applyStimulus(1'b1, 32'hF4F3F2F1, 1'b1);
    idle(10);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    doReset();
    applyStimulus(1'b1, 32'h88776655, 1'b1);
    idle(6);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      applyStimulus($urandom_range(0, 99) < 45, FRAME_W'($urandom), $urandom_range(0, 99) < 60);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
